// File: rtl/fir4_pkg.sv
// rtl/fir4_pkg.sv - shared widths, saturation limits and round/saturate helper for the FIR output stage
package fir4_pkg;

   // Accumulator width covering any output width up to 31 bits plus rounding headroom.
   localparam int ACC_W  = 40;
   localparam int DROP_W = 8;
   localparam logic [DROP_W-1:0] DROP_MAX = '1;

   typedef struct packed {
      logic                    sat;
      logic signed [ACC_W-1:0] val;
   } sat_res_t;

   function automatic logic signed [ACC_W-1:0] sat_hi(input int ow);
      return (ACC_W'(1) << (ow - 1)) - ACC_W'(1);
   endfunction

   function automatic logic signed [ACC_W-1:0] sat_lo(input int ow);
      return ~sat_hi(ow);
   endfunction

   function automatic sat_res_t sat_round(input logic signed [ACC_W-1:0] x,
                                          input logic [1:0]              sh,
                                          input int                      ow);
      logic signed [ACC_W-1:0] rnd;
      logic signed [ACC_W-1:0] r;
      logic signed [ACC_W-1:0] hi;
      logic signed [ACC_W-1:0] lo;
      sat_res_t                res;
      rnd     = (sh == 2'd0) ? '0 : (ACC_W'(1) << (sh - 2'd1));
      r       = (x + rnd) >>> sh;
      hi      = sat_hi(ow);
      lo      = sat_lo(ow);
      res.sat = (r > hi) || (r < lo);
      if (r > hi)
         res.val = hi;
      else if (r < lo)
         res.val = lo;
      else
         res.val = r;
      return res;
   endfunction

endpackage

// File: rtl/fir4_sync_fifo.sv
// rtl/fir4_sync_fifo.sv - synchronous FIFO with wrap-bit pointers; a full FIFO accepts a push when popped in the same cycle
module fir4_sync_fifo
   import fir4_pkg::*;
#(
   parameter int w     = 16,
   parameter int DEPTH = 4
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         push_i,
   input  logic [w-1:0] data_i,
   input  logic         pop_i,
   output logic         full_o,
   output logic         empty_o,
   output logic [w-1:0] head_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]  wr_ptr_q, wr_ptr_d;
   logic [AW:0]  rd_ptr_q, rd_ptr_d;
   logic [w-1:0] mem_q [DEPTH];
   logic         do_push, do_pop;

   assign empty_o = (wr_ptr_q == rd_ptr_q);
   assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);
   assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // When full, the write slot is the head being popped this cycle, so overwriting it is safe.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
   end

endmodule

// File: rtl/fir4_out_stage.sv
// rtl/fir4_out_stage.sv - FIR output stage: warm-up discard, round/shift/saturate, output FIFO with drop counting
module fir4_out_stage
   import fir4_pkg::*;
#(
   parameter int w      = 16,
   parameter int DEPTH  = 4,
   parameter int WARMUP = 3
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic signed [w+1:0] in_sum,
   input  logic [1:0]          cfg_shift,
   input  logic                out_ready,
   output logic                out_valid,
   output logic signed [w-1:0] out_data,
   output logic                sat_flag,
   output logic [DROP_W-1:0]   drop_cnt
);

   localparam int WU_W = $clog2(WARMUP + 2);

   logic [WU_W-1:0]   wu_cnt_q, wu_cnt_d;
   logic              s1_valid_q, s1_valid_d;
   logic [w-1:0]      s1_data_q, s1_data_d;
   logic              sat_q, sat_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic                    warm_done, accept, pop, drop;
   logic                    fifo_full, fifo_empty;
   logic [w-1:0]            fifo_head;
   logic signed [ACC_W-1:0] sum_ext;
   sat_res_t                rr;

   assign warm_done = (wu_cnt_q == WU_W'(WARMUP));
   assign accept    = in_valid && warm_done;
   assign sum_ext   = ACC_W'(in_sum);
   assign rr        = sat_round(sum_ext, cfg_shift, w);
   assign pop       = out_valid && out_ready;
   assign drop      = s1_valid_q && fifo_full && !pop;

   always_comb begin
      wu_cnt_d   = wu_cnt_q;
      s1_valid_d = accept;
      s1_data_d  = s1_data_q;
      sat_d      = sat_q;
      drop_d     = drop_q;
      if (in_valid && !warm_done) wu_cnt_d = wu_cnt_q + 1'b1;
      if (accept) begin
         s1_data_d = rr.val[w-1:0];
         sat_d     = sat_q | rr.sat;
      end
      if (drop && (drop_q != DROP_MAX)) drop_d = drop_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wu_cnt_q   <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         sat_q      <= 1'b0;
         drop_q     <= '0;
      end else begin
         wu_cnt_q   <= wu_cnt_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         sat_q      <= sat_d;
         drop_q     <= drop_d;
      end
   end

   fir4_sync_fifo #(
      .w     (w),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clk),
      .rst_ni  (reset),
      .push_i  (s1_valid_q),
      .data_i  (s1_data_q),
      .pop_i   (out_ready),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .head_o  (fifo_head)
   );

   assign out_valid = !fifo_empty;
   assign out_data  = fifo_head;
   assign sat_flag  = sat_q;
   assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_fir4_out_stage.sv
// tb/tb_fir4_out_stage.sv - directed self-checking bench for fir4_out_stage
module tb_fir4_out_stage;

   localparam int W = 16;

   logic                clk = 1'b0;
   logic                reset;
   logic                in_valid;
   logic signed [W+1:0] in_sum;
   logic [1:0]          cfg_shift;
   logic                out_ready;
   logic                out_valid;
   logic signed [W-1:0] out_data;
   logic                sat_flag;
   logic [7:0]          drop_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic signed [W+1:0] sum;
      logic [1:0]          sh;
      logic signed [W-1:0] exp;
      logic                sat;
   } vec_t;

   vec_t vt [10];

   always #5 clk = ~clk;

   fir4_out_stage #(.w(W), .DEPTH(4), .WARMUP(3)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_sum    (in_sum),
      .cfg_shift (cfg_shift),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .sat_flag  (sat_flag),
      .drop_cnt  (drop_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic signed [39:0] got, input logic signed [39:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic send(input logic signed [W+1:0] s, input logic [1:0] sh);
      in_valid  = 1'b1;
      in_sum    = s;
      cfg_shift = sh;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic do_reset();
      reset     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      reset = 1'b1;
   endtask

   task automatic warmup();
      repeat (3) send(18'sd0, 2'd0);
   endtask

   initial begin
      logic signed [W+1:0] wv [5];
      wv = '{18'sd4, 18'sd8, 18'sd12, 18'sd16, 18'sd20};
      vt[0] = '{ 18'sd6,      2'd2,  16'sd2,     1'b0};
      vt[1] = '{-18'sd6,      2'd2, -16'sd1,     1'b0};
      vt[2] = '{ 18'sd131068, 2'd2,  16'sd32767, 1'b0};
      vt[3] = '{-18'sd131072, 2'd2, -16'sd32768, 1'b0};
      vt[4] = '{ 18'sd5,      2'd1,  16'sd3,     1'b0};
      vt[5] = '{-18'sd9,      2'd3, -16'sd1,     1'b0};
      vt[6] = '{ 18'sd131071, 2'd3,  16'sd16384, 1'b0};
      vt[7] = '{ 18'sd40000,  2'd0,  16'sd32767, 1'b1};
      vt[8] = '{-18'sd40000,  2'd0, -16'sd32768, 1'b1};
      vt[9] = '{-18'sd131072, 2'd1, -16'sd32768, 1'b1};

      reset = 1'b0; in_valid = 1'b0; in_sum = '0; cfg_shift = '0; out_ready = 1'b0;
      do_reset();
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sat_flag", sat_flag, 0);
      chk("rst_drop_cnt", drop_cnt, 0);

      // warm-up: first three discarded, 16>>2 -> 4 then 20>>2 -> 5
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         send(wv[i], 2'd2);
         if (i == 3) chk("wu_latency_valid", out_valid, 0);
         if (i == 4) begin
            chk("wu_first_valid", out_valid, 1);
            chk("wu_first_data", out_data, 4);
         end
      end
      tick();
      chk("wu_second_valid", out_valid, 1);
      chk("wu_second_data", out_data, 5);
      tick();
      chk("wu_drained", out_valid, 0);
      out_ready = 1'b0;

      // rounding and saturation table
      for (int i = 0; i < 10; i++) begin
         send(vt[i].sum, vt[i].sh);
         chk($sformatf("vec%0d_sat", i), sat_flag, vt[i].sat);
         chk($sformatf("vec%0d_lat", i), out_valid, 0);
         tick();
         chk($sformatf("vec%0d_valid", i), out_valid, 1);
         chk($sformatf("vec%0d_data", i), out_data, vt[i].exp);
         out_ready = 1'b1;
         tick();
         out_ready = 1'b0;
      end

      // overflow: 4 stored, rest dropped, counter saturates
      do_reset();
      warmup();
      for (int i = 1; i <= 7; i++) send(18'(i), 2'd0);
      tick();
      chk("ovf_drop3", drop_cnt, 3);
      repeat (255) send(18'sd100, 2'd0);
      tick();
      chk("ovf_drop_sat", drop_cnt, 255);
      chk("ovf_head", out_data, 1);
      tick();
      chk("ovf_head_stable", out_data, 1);
      out_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         chk($sformatf("ovf_drain%0d_valid", k), out_valid, 1);
         chk($sformatf("ovf_drain%0d_data", k), out_data, k);
         tick();
      end
      chk("ovf_empty", out_valid, 0);
      out_ready = 1'b0;

      // full FIFO with simultaneous pop and push
      do_reset();
      chk("fpp_drop_cleared", drop_cnt, 0);
      warmup();
      for (int i = 10; i <= 13; i++) send(18'(i), 2'd0);
      tick();
      chk("fpp_full_head", out_data, 10);
      send(18'sd14, 2'd0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("fpp_drop", drop_cnt, 0);
      tick();
      chk("fpp_hold_data", out_data, 11);
      out_ready = 1'b1;
      for (int k = 11; k <= 14; k++) begin
         chk($sformatf("fpp_drain%0d_valid", k), out_valid, 1);
         chk($sformatf("fpp_drain%0d_data", k), out_data, k);
         tick();
      end
      chk("fpp_empty", out_valid, 0);
      out_ready = 1'b0;

      // reset mid-operation with three queued entries
      do_reset();
      warmup();
      send(18'sd40000, 2'd0);
      send(18'sd1, 2'd0);
      send(18'sd2, 2'd0);
      tick();
      chk("mr_pre_sat", sat_flag, 1);
      chk("mr_pre_valid", out_valid, 1);
      reset = 1'b0; in_valid = 1'b1; in_sum = 18'sd55;
      tick();
      reset = 1'b1; in_valid = 1'b0;
      chk("mr_valid", out_valid, 0);
      chk("mr_data", out_data, 0);
      chk("mr_drop", drop_cnt, 0);
      chk("mr_sat", sat_flag, 0);
      repeat (3) send(18'sd9, 2'd0);
      tick();
      tick();
      chk("mr_warmup_discard", out_valid, 0);
      send(18'sd77, 2'd0);
      tick();
      chk("mr_after_valid", out_valid, 1);
      chk("mr_after_data", out_data, 77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
